// File: rtl/mem_arbiter_pipeline.sv
// mem_arbiter_pipeline: 2:1 IFU/LSU memory port arbiter, LSU priority (ARB_ROUND_ROBIN_EN selects round-robin)
module mem_arbiter_pipeline #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rvalid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  state_t state, state_n;
  logic ifu_pend, lsu_pend, owner, drop;
  logic [31:0] ifu_a, lsu_a, lsu_d;
  logic lsu_w;
  logic [3:0] lsu_m;
  logic [CW-1:0] cnt;
  logic busy, ifu_ok, grant, pick_lsu, ifu_cap, lsu_cap, done, tmo, kill;
`ifdef ARB_ROUND_ROBIN_EN
  logic last;
`endif
  // arbitration, capture qualification and next-state decode (owner 1 = LSU)
  always_comb begin
    busy = state != S_IDLE;
    ifu_ok = ifu_pend & ~flush;
    grant = (state == S_IDLE) & (ifu_ok | lsu_pend);
`ifdef ARB_ROUND_ROBIN_EN
    pick_lsu = lsu_pend & (~ifu_ok | ~last);
`else
    pick_lsu = lsu_pend;
`endif
    ifu_cap = ifu_req & (flush | ~(ifu_pend | (busy & ~owner & ~drop)));
    lsu_cap = lsu_req & ~(lsu_pend | (busy & owner));
    done = (state == S_WAIT) & mem_rvalid;
    tmo = (state == S_WAIT) & ~mem_rvalid & (cnt == CW'(TIMEOUT_CYCLES - 1));
    kill = ~owner & (drop | flush);
    state_n = grant ? S_ISSUE : (state == S_ISSUE) ? S_WAIT : (done | tmo) ? S_IDLE : state;
  end
  // state register
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_n;
  // request latches, downstream port, response routing and timeout tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      ifu_pend <= 1'b0;
      lsu_pend <= 1'b0;
      owner <= 1'b0;
      drop <= 1'b0;
      cnt <= '0;
      ifu_a <= '0;
      lsu_a <= '0;
      lsu_d <= '0;
      lsu_w <= 1'b0;
      lsu_m <= '0;
      mem_req <= 1'b0;
      mem_wen <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      ifu_rvalid <= 1'b0;
      ifu_rdata <= '0;
      lsu_rvalid <= 1'b0;
      lsu_rdata <= '0;
      timeout_err <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last <= 1'b0;
`endif
    end else begin
      ifu_rvalid <= 1'b0;
      lsu_rvalid <= 1'b0;
      if (flush) ifu_pend <= 1'b0;
      if (grant) begin
        owner <= pick_lsu;
        mem_req <= 1'b1;
        mem_wen <= pick_lsu & lsu_w;
        mem_addr <= pick_lsu ? lsu_a : ifu_a;
        mem_wdata <= pick_lsu ? lsu_d : 32'h0;
        mem_wmask <= pick_lsu ? lsu_m : 4'h0;
        if (pick_lsu) lsu_pend <= 1'b0;
        else ifu_pend <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last <= pick_lsu;
`endif
      end
      if (state == S_ISSUE) begin
        mem_req <= 1'b0;
        cnt <= '0;
      end
      if (state == S_WAIT) cnt <= cnt + 1'b1;
      if (done | tmo) begin
        drop <= 1'b0;
        if (tmo) timeout_err <= 1'b1;
        if (owner) begin
          lsu_rvalid <= 1'b1;
          lsu_rdata <= done ? mem_rdata : TIMEOUT_DATA;
        end else if (!kill) begin
          ifu_rvalid <= 1'b1;
          ifu_rdata <= done ? mem_rdata : TIMEOUT_DATA;
        end
      end else if (flush & busy & ~owner) drop <= 1'b1;
      if (ifu_cap) begin
        ifu_pend <= 1'b1;
        ifu_a <= ifu_addr;
      end
      if (lsu_cap) begin
        lsu_pend <= 1'b1;
        lsu_w <= lsu_wen;
        lsu_a <= lsu_addr;
        lsu_d <= lsu_wdata;
        lsu_m <= lsu_wmask;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter_pipeline.sv
// tb_mem_arbiter_pipeline: randomized scoreboard bench for mem_arbiter_pipeline
module tb_mem_arbiter_pipeline;
  localparam int TO = 8;
  logic clk = 0, rst = 1;
  logic ifu_req = 0, lsu_req = 0, lsu_wen = 0, flush = 0, mem_rvalid = 0;
  logic [31:0] ifu_addr = 0, lsu_addr = 0, lsu_wdata = 0, mem_rdata = 0;
  logic [3:0] lsu_wmask = 0;
  logic ifu_rvalid, lsu_rvalid, mem_req, mem_wen, timeout_err;
  logic [31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_wmask;

  mem_arbiter_pipeline #(.TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .flush(flush),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit lsu;
    bit drop;
    bit tmo;
    logic [31:0] data;
    int due;
  } exp_t;
  exp_t q[$];

  int nchk = 0, nerr = 0;
  bit ifu_out = 0, lsu_out = 0, last_lsu = 0, prev_mreq = 0;
  int ifu_rc, lsu_rc, free_cyc = 0, sl_lat = 0, resp_at = -1;
  int last_mreq_cyc = -1, last_ifu_rv_cyc = -1, last_lsu_rv_cyc = -1;
  logic [31:0] ifu_a, lsu_a, lsu_d, sl_data;
  logic lsu_w;
  logic [3:0] lsu_m;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  function automatic bit ifu_busy();
    if (ifu_out) return 1;
    foreach (q[i]) if (!q[i].lsu) return 1;
    return 0;
  endfunction

  function automatic bit lsu_busy();
    if (lsu_out) return 1;
    foreach (q[i]) if (q[i].lsu) return 1;
    return 0;
  endfunction

  // slave: answers on the cycle chosen when the grant was observed
  initial forever begin
    @(posedge clk);
    #1;
    mem_rvalid = (cyc == resp_at);
    mem_rdata = mem_rvalid ? sl_data : $urandom;
  end

  // monitor: checks grants against the priority rules and responses against the queue
  always @(negedge clk) begin
    bit ie, le, wl;
    int l;
    exp_t e;
    if (!rst) begin
      ie = ifu_out && ifu_rc <= cyc - 2;
      le = lsu_out && lsu_rc <= cyc - 2;
      if (ifu_rvalid) last_ifu_rv_cyc = cyc;
      if (lsu_rvalid) last_lsu_rv_cyc = cyc;
      if (ifu_rvalid && lsu_rvalid) begin
        nchk++; nerr++;
        $display("FAIL both_rvalid: got ifu=1 lsu=1 expected at most one (cycle %0d)", cyc);
      end
      if (q.size() != 0 && q[0].due == cyc) begin
        if (q[0].drop) chk("dropped_ifu_rvalid", ifu_rvalid, 0);
        else begin
          chk(q[0].lsu ? "lsu_rvalid" : "ifu_rvalid", q[0].lsu ? lsu_rvalid : ifu_rvalid, 1);
          chk("other_rvalid", q[0].lsu ? ifu_rvalid : lsu_rvalid, 0);
          chk(q[0].lsu ? "lsu_rdata" : "ifu_rdata", q[0].lsu ? lsu_rdata : ifu_rdata, q[0].data);
          if (q[0].tmo) chk("timeout_err_set", timeout_err, 1);
        end
        void'(q.pop_front());
      end else if (ifu_rvalid || lsu_rvalid) begin
        nchk++; nerr++;
        $display("FAIL unexpected_rvalid: got ifu=%b lsu=%b expected none (cycle %0d)", ifu_rvalid, lsu_rvalid, cyc);
      end
      if (mem_req) begin
        chk("mreq_one_cycle", prev_mreq, 0);
        chk("mreq_port_free", cyc >= free_cyc, 1);
        if (!ie && !le) begin
          nchk++; nerr++;
          $display("FAIL spurious_grant: got mem_req=1 expected no eligible request (cycle %0d)", cyc);
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
          wl = le && (!ie || !last_lsu);
`else
          wl = le;
`endif
          chk("mem_wen", mem_wen, wl ? lsu_w : 1'b0);
          chk("mem_addr", mem_addr, wl ? lsu_a : ifu_a);
          chk("mem_wmask", mem_wmask, wl ? lsu_m : 4'h0);
          if (wl) chk("mem_wdata", mem_wdata, lsu_d);
          last_lsu = wl;
          if (wl) lsu_out = 0;
          else ifu_out = 0;
          l = sl_lat == 0 ? $urandom_range(1, TO) : sl_lat;
          e.lsu = wl;
          e.drop = 0;
          e.tmo = l > TO;
          e.data = e.tmo ? 32'hDEAD_BEEF : $urandom;
          e.due = cyc + (e.tmo ? TO + 1 : l + 1);
          resp_at = e.tmo ? -1 : cyc + l;
          sl_data = e.data;
          free_cyc = e.due + 1;
          q.push_back(e);
          last_mreq_cyc = cyc;
        end
      end else if ((ie || le) && cyc >= free_cyc) begin
        nchk++; nerr++;
        $display("FAIL grant_stall: got mem_req=0 expected a grant (cycle %0d)", cyc);
      end
    end
    prev_mreq = mem_req;
  end

  task automatic step();
    @(posedge clk);
    #1;
    ifu_req = 0;
    lsu_req = 0;
    flush = 0;
  endtask

  task automatic ifu_issue(input logic [31:0] a);
    ifu_req = 1; ifu_addr = a;
    ifu_out = 1; ifu_rc = cyc; ifu_a = a;
  endtask

  task automatic lsu_issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    lsu_req = 1; lsu_wen = w; lsu_addr = a; lsu_wdata = d; lsu_wmask = m;
    lsu_out = 1; lsu_rc = cyc; lsu_w = w; lsu_a = a; lsu_d = d; lsu_m = m;
  endtask

  task automatic model_clear();
    q.delete();
    ifu_out = 0; lsu_out = 0; last_lsu = 0; free_cyc = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || ifu_out || lsu_out) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      nchk++; nerr++;
      $display("FAIL drain_timeout: got %0d entries outstanding expected 0", q.size());
    end
  endtask

  task automatic wait_grant();
    int n = 0;
    while (q.size() == 0 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      nchk++; nerr++;
      $display("FAIL grant_timeout: got no mem_req expected one within 20 cycles");
    end
  endtask

  task automatic chk_reset(input string t);
    @(negedge clk);
    chk({t, "_mem_req"}, mem_req, 0);
    chk({t, "_mem_wen"}, mem_wen, 0);
    chk({t, "_mem_wmask"}, mem_wmask, 0);
    chk({t, "_mem_addr"}, mem_addr, 0);
    chk({t, "_mem_wdata"}, mem_wdata, 0);
    chk({t, "_ifu_rvalid"}, ifu_rvalid, 0);
    chk({t, "_lsu_rvalid"}, lsu_rvalid, 0);
    chk({t, "_ifu_rdata"}, ifu_rdata, 0);
    chk({t, "_lsu_rdata"}, lsu_rdata, 0);
    chk({t, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    int c0;
    model_clear();
    step(); step(); step();
    rst = 0;
    chk_reset("reset");
    sl_lat = 2;
    step();
    c0 = cyc;
    ifu_issue(32'h8000_0000);
    drain();
    chk("ifu_req_to_mem_req", last_mreq_cyc - c0, 2);
    chk("ifu_req_to_rvalid", last_ifu_rv_cyc - c0, 5);
    chk("lsu_rvalid_quiet", last_lsu_rv_cyc, -1);
    sl_lat = 0;
    step();
    ifu_issue(32'h8000_0010);
    lsu_issue(1'b0, 32'h0F00_0004, 32'h0, 4'h0);
    drain();
    chk("collision_lsu_first", last_lsu_rv_cyc < last_ifu_rv_cyc, 1);
    step();
    lsu_issue(1'b1, 32'h0F00_0002, 32'h00AB_0000, 4'b0100);
    drain();
    repeat (400) begin
      step();
      if (!ifu_busy() && $urandom_range(0, 2) == 0) ifu_issue($urandom);
      if (!lsu_busy() && $urandom_range(0, 2) == 0)
        lsu_issue(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
    end
    drain();
    sl_lat = 5;
    step();
    ifu_issue(32'h8000_0100);
    wait_grant();
    c0 = cyc;
    flush = 1;
    foreach (q[i]) if (!q[i].lsu) q[i].drop = 1;
    ifu_issue(32'h8000_0104);
    sl_lat = 0;
    drain();
    chk("refetch_rvalid", last_ifu_rv_cyc > c0 + 5, 1);
    chk("timeout_err_clear", timeout_err, 0);
    sl_lat = 255;
    step();
    lsu_issue(1'b0, 32'h0F00_0008, 32'h0, 4'h0);
    drain();
    repeat (5) step();
    chk("timeout_err_sticky", timeout_err, 1);
    sl_lat = 6;
    step();
    lsu_issue(1'b0, 32'h0F00_000C, 32'h0, 4'h0);
    wait_grant();
    step();
    rst = 1;
    model_clear();
    step(); step();
    rst = 0;
    repeat (4) step();
    chk_reset("post_reset");
    sl_lat = 0;
    repeat (60) begin
      step();
      if (!ifu_busy() && $urandom_range(0, 1) == 0) ifu_issue($urandom);
      if (!lsu_busy() && $urandom_range(0, 1) == 0)
        lsu_issue(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
